// File: rtl/ssd_scan_mux.sv
// Multiplexed seven-segment scan driver: time-slices NUM_DIGITS pre-encoded digits onto
// one segment bus with blanking, blink, decimal points, PWM brightness and a dead cycle.
module ssd_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 18,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7*NUM_DIGITS-1:0] digits_ssd,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              display_ssd,
    output logic                    display_dp,
    output logic [2:0]              scan_index,
    output logic                    frame_tick
);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [REFRESH_BITS-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]              scan_q, scan_d;
    logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              ssd_q, ssd_d;
    logic                    dp_q, dp_d;
    logic [2:0]              scan_index_q, scan_index_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_wrap;
    logic                    pwm_on;
    logic                    visible;
    logic                    sel_en, sel_blink, sel_dp;
    logic [6:0]              sel_ssd;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    always_comb begin
        slot_cnt_d    = slot_cnt_q + 1'b1;
        slot_wrap     = &slot_cnt_q;
        scan_d        = scan_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;

        if (slot_wrap) begin
            if (scan_q == 3'(NUM_DIGITS - 1)) begin
                scan_d = 3'd0;
                // A frame just completed; the blink phase flips every BLINK_FRAMES frames.
                if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end else begin
                scan_d = scan_q + 3'd1;
            end
        end

        sel_en     = 1'b0;
        sel_blink  = 1'b0;
        sel_dp     = 1'b0;
        sel_ssd    = 7'h7F;
        sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_q == 3'(i)) begin
                sel_en        = digit_en[i];
                sel_blink     = blink_mask[i];
                sel_dp        = dp_mask[i];
                sel_ssd       = digits_ssd[7*i +: 7];
                sel_onehot[i] = 1'b1;
            end
        end

        pwm_on  = (brightness == 4'hF) || (slot_cnt_q[REFRESH_BITS-1 -: 4] < brightness);
        // Slot count 0 is the anti-ghosting dead cycle between digits.
        visible = sel_en && !(sel_blink && blink_phase_q) &&
                  (slot_cnt_q != '0) && pwm_on;

        anode_d = '1;
        ssd_d   = 7'h7F;
        dp_d    = 1'b1;
        if (visible) begin
            anode_d = ~sel_onehot;
            ssd_d   = sel_ssd;
            dp_d    = ~sel_dp;
        end

        scan_index_d = scan_q;
        frame_tick_d = (slot_cnt_q == '0) && (scan_q == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_cnt_q    <= '0;
            scan_q        <= 3'd0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            anode_q       <= '1;
            ssd_q         <= 7'h7F;
            dp_q          <= 1'b1;
            scan_index_q  <= 3'd0;
            frame_tick_q  <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            scan_q        <= scan_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            anode_q       <= anode_d;
            ssd_q         <= ssd_d;
            dp_q          <= dp_d;
            scan_index_q  <= scan_index_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign anode       = anode_q;
    assign display_ssd = ssd_q;
    assign display_dp  = dp_q;
    assign scan_index  = scan_index_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed bench for ssd_scan_mux with 6 digits, 16-clock slots and 2-frame blink.
module tb_ssd_scan_mux;
  localparam int N  = 6;
  localparam int RB = 4;
  localparam int BF = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [7*N-1:0] digits_ssd;
  logic [N-1:0]   digit_en, blink_mask, dp_mask;
  logic [3:0]     brightness;
  logic [N-1:0]   anode;
  logic [6:0]     display_ssd;
  logic           display_dp;
  logic [2:0]     scan_index;
  logic           frame_tick;

  int errors = 0;
  int checks = 0;
  int cyc    = -1;

  ssd_scan_mux #(.NUM_DIGITS(N), .REFRESH_BITS(RB), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .digits_ssd(digits_ssd), .digit_en(digit_en),
    .blink_mask(blink_mask), .dp_mask(dp_mask), .brightness(brightness),
    .anode(anode), .display_ssd(display_ssd), .display_dp(display_dp),
    .scan_index(scan_index), .frame_tick(frame_tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // outputs visible now reflect counter time cyc (counted from reset release)
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_time_model();
    int slot, d, blink;
    logic vis;
    logic [N-1:0] e_an;
    logic [6:0] e_ssd;
    logic e_dp;
    slot  = cyc % 16;
    d     = (cyc / 16) % N;
    blink = (cyc / 192) % 2;
    vis   = digit_en[d] && !(blink_mask[d] && blink == 1) && slot != 0 &&
            (brightness == 4'hF || slot < int'(brightness));
    e_an  = vis ? ~(N'(1) << d) : {N{1'b1}};
    e_ssd = vis ? digits_ssd[7*d +: 7] : 7'h7F;
    e_dp  = vis ? ~dp_mask[d] : 1'b1;
    check_eq("anode", 32'(anode), 32'(e_an));
    check_eq("ssd", 32'(display_ssd), 32'(e_ssd));
    check_eq("dp", 32'(display_dp), 32'(e_dp));
    check_eq("frame_tick", 32'(frame_tick), 32'(cyc % 96 == 0));
    check_eq("scan_index", 32'(scan_index), 32'(d));
  endtask

  task automatic set_phase(input int n);
    digit_en = 6'h3F; blink_mask = '0; dp_mask = '0; brightness = 4'hF;
    if (n >= 192 && n < 288) begin
      digit_en = 6'b101101; dp_mask = 6'b000100;
    end else if (n >= 288 && n < 672) begin
      blink_mask = 6'b000011;
    end else if (n >= 672 && n < 768) begin
      brightness = 4'd4;
    end else if (n >= 768 && n < 864) begin
      brightness = 4'd0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_anode"}, 32'(anode), 32'h3F);
    check_eq({tag, "_ssd"}, 32'(display_ssd), 32'h7F);
    check_eq({tag, "_dp"}, 32'(display_dp), 32'h1);
    check_eq({tag, "_ft"}, 32'(frame_tick), 32'h0);
    check_eq({tag, "_idx"}, 32'(scan_index), 32'h0);
  endtask

  initial begin
    reset      = 1'b0;
    digits_ssd = {7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30};
    set_phase(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    reset = 1'b1;
    cyc   = -1;
    for (int n = 0; n <= 920; n++) begin
      set_phase(n);
      step();
      check_time_model();
      case (cyc)
        0:   begin check_eq("d_ft0", 32'(frame_tick), 32'h1); check_eq("d_dead0", 32'(anode), 32'h3F); end
        1:   begin check_eq("d_an1", 32'(anode), 32'h3E); check_eq("d_ssd1", 32'(display_ssd), 32'h30); end
        15:  check_eq("d_an15", 32'(anode), 32'h3E);
        16:  check_eq("d_dead16", 32'(anode), 32'h3F);
        17:  begin check_eq("d_an17", 32'(anode), 32'h3D); check_eq("d_ssd17", 32'(display_ssd), 32'h6D); end
        95:  begin check_eq("d_an95", 32'(anode), 32'h1F); check_eq("d_ssd95", 32'(display_ssd), 32'h5F); end
        96:  check_eq("d_ft96", 32'(frame_tick), 32'h1);
        213: begin check_eq("d_blank1", 32'(anode), 32'h3F); check_eq("d_blank1s", 32'(display_ssd), 32'h7F); end
        229: begin check_eq("d_dp2", 32'(display_dp), 32'h0); check_eq("d_an2", 32'(anode), 32'h3B); end
        289: check_eq("d_blinkoff", 32'(anode), 32'h3F);
        321: check_eq("d_blink_d2", 32'(anode), 32'h3B);
        385: check_eq("d_blinkon", 32'(anode), 32'h3E);
        675: check_eq("d_pwm_lit", 32'(anode), 32'h3E);
        676: check_eq("d_pwm_dark", 32'(anode), 32'h3F);
        770: check_eq("d_pwm0", 32'(anode), 32'h3F);
        default: ;
      endcase
    end

    // counter state is now digit 3, slot 9
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");

    reset = 1'b1;
    cyc   = -1;
    digit_en = 6'h3F; blink_mask = 6'b000011; dp_mask = '0; brightness = 4'hF;
    for (int n = 0; n < 200; n++) begin
      if (n == 41) digits_ssd[20:14] = 7'h12;
      step();
      check_time_model();
      case (cyc)
        0:  begin check_eq("r_ft0", 32'(frame_tick), 32'h1); check_eq("r_idx0", 32'(scan_index), 32'h0); end
        1:  check_eq("r_blink0", 32'(anode), 32'h3E);
        40: check_eq("r_old", 32'(display_ssd), 32'h79);
        41: check_eq("r_new", 32'(display_ssd), 32'h12);
        default: ;
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
